sseg_scan: RTL and testbench
============================

// Module: sseg_scan
// PURPOSE
//  Parametrised multiplexed seven-segment driver, successor to sseg_drv. Scans DIGITS
//  common-anode/cathode digits at a programmed rate. Hex-decode or raw-segment mode,
//  per-digit decimal points, leading-zero blanking, PWM brightness, tear-free frame update.
//  Sits between register/status logic and the board display pins.
// PARAMETERS
//  DIGITS         8            number of digits scanned (1..16)
//  CLK_HZ         100_000_000  clk frequency
//  SCAN_HZ        1_000        per-digit slot rate; DIV = CLK_HZ/SCAN_HZ clocks per slot (>=2)
//  PWM_BITS       4            brightness resolution
//  AN_ACT_LOW     1            1: an active-low
//  SEG_ACT_LOW    1            1: seg active-low
// PORTS
//  clk     in   1              system clock
//  rst     in   1              synchronous, active-high reset
//  en      in   1              1: scanning; 0: display dark
//  mod     in   1              0: hex decode of dat; 1: raw segments from raw
//  dat     in   4*DIGITS       hex nibbles, digit i = dat[4i+3:4i]
//  raw     in   8*DIGITS       raw segments, digit i = raw[8i+7:8i] as {dp,g,f,e,d,c,b,a}
//  dp      in   DIGITS         decimal point per digit (hex mode only)
//  blank_lz in  1              1: blank leading zero digits (hex mode only)
//  bright  in   PWM_BITS       brightness; 0 = dark, all-ones = full on
//  an      out  DIGITS         digit enables, one-hot active
//  seg     out  8              {dp,g,f,e,d,c,b,a}
//  idx     out  $clog2(DIGITS) digit currently scanned
// BEHAVIOUR
//  - Reset: pre_cnt=0, idx=0, pwm_cnt=0, shadow regs=0; an and seg all inactive
//    (all ones when *_ACT_LOW=1). Reset mid-frame aborts the frame immediately.
//  - Prescaler pre_cnt counts 0..DIV-1 while en=1; tick when pre_cnt==DIV-1. On tick
//    idx increments, wrapping DIGITS-1 -> 0. en=0: pre_cnt, idx, pwm_cnt held at 0.
//  - Shadow: dat/raw/dp/mod/blank_lz copied to shadow regs every cycle while en=0, and
//    when en=1 only on the tick that wraps idx to 0. Mid-frame input changes never appear
//    until the next frame (no tearing). bright is NOT shadowed (applies next cycle).
//  - Hex decode (active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//    A:77 b:7C C:39 d:5E E:79 F:71; bit7 = shadow dp[idx].
//  - Raw mode: seg pattern = shadow raw byte of idx, unmodified.
//  - Leading-zero blank: hex mode, blank_lz=1: digit idx>0 is dark when its nibble and
//    all higher nibbles are zero. Digit 0 always shown ("0" for all-zero data).
//  - PWM: pwm_cnt free-runs (PWM_BITS wide) while en=1. lit = (bright==all-ones) |
//    (pwm_cnt < bright). bright=0 -> never lit.
//  - Output: an[idx] active iff en & lit & ~blanked; else all an inactive. seg = pattern
//    when digit active, else all inactive. Polarity applied last. an/seg/idx registered:
//    outputs reflect state of previous cycle (1-clk latency). an never has >1 active bit.
//  - en 1->0: outputs inactive on next edge. en 0->1: digit 0 shown first, DIV clocks.
// STRUCTURE
//  - Package sseg_pkg: 16-entry hex-to-segment constant table, segment bit-position
//    localparams, function to compute DIV/clog2 widths; shared with sseg_drv.
//  - Sub-module sseg_hex_dec (nibble -> 7-bit pattern, combinational), instanced once
//    on the muxed nibble. Prescaler, idx, PWM, shadow and blanking logic stay in top.
// TESTING  (bench params: DIGITS=8, CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, PWM_BITS=4)
//  1 rst=1 for 3 clks, en=0 -> an=8'hFF, seg=8'hFF, idx=0; holds after rst release.
//  2 dat=32'h12345678, mod=0, dp=0, bright=4'hF, en=1 -> an=FE seg=80 ("8") 10 clks,
//    then an=FD seg=F8 ("7"), ... an=7F seg=F9 ("1"); idx wraps 7->0 after 80 clks.
//  3 mod=1, raw[7:0]=8'h81, en=1 -> digit 0 slot: an=FE, seg=8'h7E.
//  4 dat=32'h000000A0, blank_lz=1 -> digit0 seg=C0, digit1 seg=88, digits 2..7 an=FF.
//  5 dat changed 12345678->87654321 while idx=3 -> digits 3..7 still show old values;
//    new values from next idx=0; reset asserted at idx=5 -> an=FF, idx=0 next clk.
//  6 bright=4 -> within each slot an active exactly when pwm_cnt<4 (4 of 16 clks);
//    bright=0 -> an=FF throughout; bright=F -> an active every slot clock.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display drivers (sseg_drv, sseg_scan):
// segment bit positions, the hex glyph table and parameter-derivation helpers.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Full segment byte {dp,g,f,e,d,c,b,a}, active-high
    typedef logic [7:0] seg_t;

    // Active-high glyphs for 0..9, A, b, C, d, E, F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int scan_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/sseg_hex_dec.sv
// Combinational hex nibble to active-high seven-segment glyph.
module sseg_hex_dec
    import sseg_pkg::*;
(
    input  logic [3:0]         nib_i,
    output logic [SEG_G:SEG_A] seg_o
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        seg_o = HEX_SEG[nib_i];
    end

endmodule

// File: rtl/sseg_scan.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-shadowed data,
// hex/raw modes, leading-zero blanking and PWM brightness, all outputs registered.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int PWM_BITS    = 4,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1,
    localparam int IW         = width_of(DIGITS)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mod,
    input  logic [4*DIGITS-1:0]   dat,
    input  logic [8*DIGITS-1:0]   raw,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic [IW-1:0]         idx
);

    localparam int                DIV      = scan_div(CLK_HZ, SCAN_HZ);
    localparam int                PW       = width_of(DIV);
    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACT_LOW != 0}};
    localparam seg_t              SEG_OFF  = {8{SEG_ACT_LOW != 0}};

    logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;

    logic                mod_sh_q;
    logic                blz_sh_q;
    logic [DIGITS-1:0]   dp_sh_q;
    logic [3:0]          dat_sh_q [DIGITS];
    seg_t                raw_sh_q [DIGITS];

    logic [DIGITS-1:0]   an_q, an_d;
    seg_t                seg_q, seg_d;
    logic [IW-1:0]       idx_out_q;

    logic                tick_s;
    logic                load_s;
    logic                lz_s;
    logic                blank_s;
    logic                lit_s;
    logic                active_s;
    logic [3:0]          nib_s;
    logic [6:0]          hex_seg_s;
    seg_t                pattern_s;

    sseg_hex_dec u_hex_dec (
        .nib_i (nib_s),
        .seg_o (hex_seg_s)
    );

    // Prescaler, digit index and PWM counter; all parked at zero while disabled
    always_comb begin
        tick_s = (pre_cnt_q == PRE_LAST);
        if (en) begin
            pre_cnt_d = tick_s ? '0 : pre_cnt_q + PW'(1);
            if (tick_s) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                idx_d = idx_q;
            end
            pwm_d = pwm_q + PWM_BITS'(1);
        end else begin
            pre_cnt_d = '0;
            idx_d     = '0;
            pwm_d     = '0;
        end
        // Shadow follows inputs while dark, otherwise only at the frame boundary
        load_s = !en || (tick_s && (idx_q == IDX_LAST));
    end

    // Segment pattern, leading-zero blanking and brightness gating for the current digit
    always_comb begin
        nib_s   = dat_sh_q[idx_q];
        lz_s    = 1'b1;
        blank_s = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_s    = lz_s && (dat_sh_q[i] == 4'h0);
            blank_s = (IW'(i) == idx_q) ? lz_s : blank_s;
        end
        blank_s = blank_s && !mod_sh_q && blz_sh_q;

        if (mod_sh_q) begin
            pattern_s = raw_sh_q[idx_q];
        end else begin
            pattern_s         = {1'b0, hex_seg_s};
            pattern_s[SEG_DP] = dp_sh_q[idx_q];
        end

        lit_s    = (&bright) || (pwm_q < bright);
        active_s = en && lit_s && !blank_s;

        if (active_s) begin
            an_d  = (DIGITS'(1) << idx_q) ^ AN_OFF;
            seg_d = pattern_s ^ SEG_OFF;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // Counters, frame shadow registers and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            mod_sh_q  <= 1'b0;
            blz_sh_q  <= 1'b0;
            dp_sh_q   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                dat_sh_q[i] <= 4'h0;
                raw_sh_q[i] <= 8'h00;
            end
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            idx_out_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            if (load_s) begin
                mod_sh_q <= mod;
                blz_sh_q <= blank_lz;
                dp_sh_q  <= dp;
                for (int i = 0; i < DIGITS; i++) begin
                    dat_sh_q[i] <= dat[4*i +: 4];
                    raw_sh_q[i] <= raw[8*i +: 8];
                end
            end
            an_q      <= an_d;
            seg_q     <= seg_d;
            idx_out_q <= idx_q;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign idx = idx_out_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed self-checking bench for sseg_scan with DIGITS=8, DIV=10, PWM_BITS=4.
module tb_sseg_scan;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic        mod      = 1'b0;
    logic        blank_lz = 1'b0;
    logic [31:0] dat      = 32'h0;
    logic [63:0] raw      = 64'h0;
    logic [7:0]  dp       = 8'h00;
    logic [3:0]  bright   = 4'hF;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [2:0]  idx;

    int ncmp = 0;
    int nerr = 0;
    int k    = 0;
    int d    = 0;
    bit lit  = 1'b0;

    // Active-low glyphs of 12345678 by digit position 0..7 ("8","7",...,"1")
    logic [7:0] seg_fwd [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    always #5 clk = ~clk;

    sseg_scan #(
        .DIGITS      (8),
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .PWM_BITS    (4),
        .AN_ACT_LOW  (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mod      (mod),
        .dat      (dat),
        .raw      (raw),
        .dp       (dp),
        .blank_lz (blank_lz),
        .bright   (bright),
        .an       (an),
        .seg      (seg),
        .idx      (idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] an_of(input int dig);
        logic [7:0] one;
        one = 8'h01;
        return 8'hFF ^ (one << dig);
    endfunction

    task automatic cyc_chk(input string tag, input logic [7:0] an_e, input logic [7:0] seg_e);
        @(negedge clk);
        chk({tag, "_an"}, {24'h0, an}, {24'h0, an_e});
        chk({tag, "_seg"}, {24'h0, seg}, {24'h0, seg_e});
    endtask

    task automatic go_dark();
        en = 1'b0;
        cyc_chk("dark", 8'hFF, 8'hFF);
    endtask

    initial begin
        // 1: reset with en=0, then hold after release
        repeat (3) @(negedge clk);
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_idx", {29'h0, idx}, 32'h0);
        rst = 1'b0;
        cyc_chk("rel", 8'hFF, 8'hFF);
        chk("rel_idx", {29'h0, idx}, 32'h0);

        // 2: hex scan of 12345678 at full brightness
        dat = 32'h12345678;
        @(negedge clk);
        en = 1'b1;
        for (int dg = 0; dg < 8; dg++) begin
            for (int c = 0; c < 10; c++) begin
                cyc_chk("hex", an_of(dg), seg_fwd[dg]);
                chk("hex_idx", {29'h0, idx}, 32'(dg));
            end
        end
        cyc_chk("wrap", 8'hFE, 8'h80);
        chk("wrap_idx", {29'h0, idx}, 32'h0);
        go_dark();

        // 3: raw mode, digit 0 = 0x81, other digits blank pattern
        mod = 1'b1;
        raw = 64'h0000_0000_0000_0081;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 10; c++) cyc_chk("raw0", 8'hFE, 8'h7E);
        cyc_chk("raw1", 8'hFD, 8'hFF);
        go_dark();

        // 4: leading-zero blanking of 000000A0
        mod      = 1'b0;
        raw      = 64'h0;
        dat      = 32'h000000A0;
        blank_lz = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int dg = 0; dg < 8; dg++) begin
            for (int c = 0; c < 10; c++) begin
                if (dg == 0)      cyc_chk("lz0", 8'hFE, 8'hC0);
                else if (dg == 1) cyc_chk("lz1", 8'hFD, 8'h88);
                else              cyc_chk("lzb", 8'hFF, 8'hFF);
            end
        end
        go_dark();

        // Decimal point on digit 0, zeros shown without blanking
        dat      = 32'h0;
        blank_lz = 1'b0;
        dp       = 8'h01;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 10; c++) cyc_chk("dp0", 8'hFE, 8'h40);
        cyc_chk("dp1", 8'hFD, 8'hC0);
        go_dark();

        // 5: mid-frame data change at idx=3, then reset at idx=5
        dp  = 8'h00;
        dat = 32'h12345678;
        @(negedge clk);
        en = 1'b1;
        for (int dg = 0; dg < 3; dg++)
            for (int c = 0; c < 10; c++) cyc_chk("old_a", an_of(dg), seg_fwd[dg]);
        dat = 32'h87654321;
        for (int dg = 3; dg < 8; dg++)
            for (int c = 0; c < 10; c++) cyc_chk("old_b", an_of(dg), seg_fwd[dg]);
        for (int dg = 0; dg < 8; dg++)
            for (int c = 0; c < 10; c++) cyc_chk("new", an_of(dg), seg_fwd[7-dg]);
        for (int dg = 0; dg < 5; dg++)
            for (int c = 0; c < 10; c++) cyc_chk("new2", an_of(dg), seg_fwd[7-dg]);
        rst = 1'b1;
        cyc_chk("midrst", 8'hFF, 8'hFF);
        chk("midrst_idx", {29'h0, idx}, 32'h0);
        rst = 1'b0;
        cyc_chk("postrst", 8'hFE, 8'hC0);
        chk("postrst_idx", {29'h0, idx}, 32'h0);
        go_dark();

        // 6: PWM brightness 4, then 0, then full
        dat    = 32'h12345678;
        bright = 4'h4;
        @(negedge clk);
        en = 1'b1;
        k  = 0;
        for (int c = 0; c < 80; c++) begin
            d   = (k / 10) % 8;
            lit = ((k % 16) < 4);
            if (lit) cyc_chk("pwm4", an_of(d), seg_fwd[d]);
            else     cyc_chk("pwm4", 8'hFF, 8'hFF);
            k++;
        end
        bright = 4'h0;
        for (int c = 0; c < 32; c++) begin
            cyc_chk("pwm0", 8'hFF, 8'hFF);
            k++;
        end
        bright = 4'hF;
        for (int c = 0; c < 32; c++) begin
            d = (k / 10) % 8;
            cyc_chk("pwmF", an_of(d), seg_fwd[d]);
            k++;
        end
        go_dark();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
